// File: rtl/account_store.sv
// Account table with card lookup, PIN verification, retry lockout and balance commit.
module account_store #(
  parameter int unsigned NUM_ACCOUNTS   = 4,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 14,
  localparam int unsigned IDXW = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            prog_en_i,
  input  logic [IDXW-1:0] prog_idx_i,
  input  logic [7:0]      prog_cardno_i,
  input  logic [3:0]      prog_pin_i,
  input  logic [4:0]      prog_balance_i,
  input  logic            card_valid_i,
  input  logic [7:0]      cardno_i,
  output logic            card_ready_o,
  input  logic            pin_valid_i,
  input  logic [3:0]      pin_i,
  input  logic            txn_valid_i,
  input  logic [4:0]      txn_balance_i,
  input  logic            session_end_i,
  output logic            auth_ok_o,
  output logic            auth_fail_o,
  output logic            card_reject_o,
  output logic            card_locked_o,
  output logic            timeout_o,
  output logic            session_active_o,
  output logic [3:0]      correct_pin_o,
  output logic [4:0]      current_balance_o
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WAIT_PIN, S_SESSION} state_e;

  state_e          state_q;
  logic [7:0]      tbl_card_q  [NUM_ACCOUNTS];
  logic [3:0]      tbl_pin_q   [NUM_ACCOUNTS];
  logic [4:0]      tbl_bal_q   [NUM_ACCOUNTS];
  logic            tbl_lock_q  [NUM_ACCOUNTS];
  logic [2:0]      tbl_fails_q [NUM_ACCOUNTS];
  logic [7:0]      card_q;
  logic [IDXW-1:0] idx_q;
  logic [TW-1:0]   timer_q;

  logic       auth_ok_q, auth_fail_q, card_reject_q, card_locked_q, timeout_q;
  logic       session_active_q;
  logic [3:0] correct_pin_q;
  logic [4:0] current_balance_q;

  // Card acceptance is gated by programming so a table write always wins.
  assign card_ready_o = (state_q == S_IDLE) && !prog_en_i;

  // Session FSM, table storage and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      card_q            <= '0;
      idx_q             <= '0;
      timer_q           <= '0;
      auth_ok_q         <= 1'b0;
      auth_fail_q       <= 1'b0;
      card_reject_q     <= 1'b0;
      card_locked_q     <= 1'b0;
      timeout_q         <= 1'b0;
      session_active_q  <= 1'b0;
      correct_pin_q     <= '0;
      current_balance_q <= '0;
      for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
        tbl_card_q[i]  <= '0;
        tbl_pin_q[i]   <= '0;
        tbl_bal_q[i]   <= '0;
        tbl_lock_q[i]  <= 1'b0;
        tbl_fails_q[i] <= '0;
      end
    end else begin
      auth_ok_q     <= 1'b0;
      auth_fail_q   <= 1'b0;
      card_reject_q <= 1'b0;
      card_locked_q <= 1'b0;
      timeout_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (prog_en_i) begin
            tbl_card_q[prog_idx_i]  <= prog_cardno_i;
            tbl_pin_q[prog_idx_i]   <= prog_pin_i;
            tbl_bal_q[prog_idx_i]   <= prog_balance_i;
            tbl_lock_q[prog_idx_i]  <= 1'b0;
            tbl_fails_q[prog_idx_i] <= '0;
          end else if (card_valid_i && (cardno_i != '0)) begin
            card_q  <= cardno_i;
            idx_q   <= '0;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          // Sequential scan, so the lowest matching index wins.
          if (tbl_card_q[idx_q] == card_q) begin
            if (tbl_lock_q[idx_q]) begin
              card_reject_q <= 1'b1;
              card_locked_q <= 1'b1;
              state_q       <= S_IDLE;
            end else begin
              correct_pin_q     <= tbl_pin_q[idx_q];
              current_balance_q <= tbl_bal_q[idx_q];
              timer_q           <= '0;
              state_q           <= S_WAIT_PIN;
            end
          end else if (idx_q == IDXW'(NUM_ACCOUNTS - 1)) begin
            card_reject_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        S_WAIT_PIN: begin
          if (pin_valid_i) begin
            timer_q <= '0;
            if (pin_i == tbl_pin_q[idx_q]) begin
              auth_ok_q          <= 1'b1;
              tbl_fails_q[idx_q] <= '0;
              session_active_q   <= 1'b1;
              state_q            <= S_SESSION;
            end else begin
              auth_fail_q <= 1'b1;
              if ((tbl_fails_q[idx_q] + 3'd1) == 3'(MAX_TRIES)) begin
                tbl_fails_q[idx_q] <= 3'(MAX_TRIES);
                tbl_lock_q[idx_q]  <= 1'b1;
                card_locked_q      <= 1'b1;
                correct_pin_q      <= '0;
                current_balance_q  <= '0;
                state_q            <= S_IDLE;
              end else begin
                tbl_fails_q[idx_q] <= tbl_fails_q[idx_q] + 3'd1;
              end
            end
          end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_q         <= 1'b1;
            correct_pin_q     <= '0;
            current_balance_q <= '0;
            state_q           <= S_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_SESSION: begin
          if (txn_valid_i) begin
            tbl_bal_q[idx_q]  <= txn_balance_i;
            current_balance_q <= txn_balance_i;
            timer_q           <= '0;
          end
          // End of session overrides the balance echo; the commit above still lands.
          if (session_end_i) begin
            session_active_q  <= 1'b0;
            correct_pin_q     <= '0;
            current_balance_q <= '0;
            state_q           <= S_IDLE;
          end else if (!txn_valid_i) begin
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
              timeout_q         <= 1'b1;
              session_active_q  <= 1'b0;
              correct_pin_q     <= '0;
              current_balance_q <= '0;
              state_q           <= S_IDLE;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign auth_ok_o         = auth_ok_q;
  assign auth_fail_o       = auth_fail_q;
  assign card_reject_o     = card_reject_q;
  assign card_locked_o     = card_locked_q;
  assign timeout_o         = timeout_q;
  assign session_active_o  = session_active_q;
  assign correct_pin_o     = correct_pin_q;
  assign current_balance_o = current_balance_q;

endmodule

// File: tb/tb_account_store.sv
// Scoreboard bench for account_store: stimulus pushes expected output events, a monitor pops and compares.
module tb_account_store;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_en;
  logic [1:0] prog_idx;
  logic [7:0] prog_cardno;
  logic [3:0] prog_pin;
  logic [4:0] prog_balance;
  logic       card_valid;
  logic [7:0] cardno;
  logic       card_ready;
  logic       pin_valid;
  logic [3:0] pin;
  logic       txn_valid;
  logic [4:0] txn_balance;
  logic       session_end;
  logic       auth_ok, auth_fail, card_reject, card_locked, timeout, session_active;
  logic [3:0] correct_pin;
  logic [4:0] current_balance;

  account_store dut (
    .clk               (clk),
    .rst               (rst),
    .prog_en_i         (prog_en),
    .prog_idx_i        (prog_idx),
    .prog_cardno_i     (prog_cardno),
    .prog_pin_i        (prog_pin),
    .prog_balance_i    (prog_balance),
    .card_valid_i      (card_valid),
    .cardno_i          (cardno),
    .card_ready_o      (card_ready),
    .pin_valid_i       (pin_valid),
    .pin_i             (pin),
    .txn_valid_i       (txn_valid),
    .txn_balance_i     (txn_balance),
    .session_end_i     (session_end),
    .auth_ok_o         (auth_ok),
    .auth_fail_o       (auth_fail),
    .card_reject_o     (card_reject),
    .card_locked_o     (card_locked),
    .timeout_o         (timeout),
    .session_active_o  (session_active),
    .correct_pin_o     (correct_pin),
    .current_balance_o (current_balance)
  );

  always #5 clk = ~clk;

  // Pulses packed as {auth_ok, auth_fail, card_reject, card_locked, timeout}.
  typedef struct {
    int         at;
    logic [4:0] p;
    logic       sa;
    logic [3:0] cp;
    logic [4:0] cb;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: an event is any pulse or any change of the session-visible outputs.
  logic [9:0] prev_st = '0;
  always @(negedge clk) begin
    logic [4:0] p;
    logic [9:0] st;
    exp_t       e;
    p  = {auth_ok, auth_fail, card_reject, card_locked, timeout};
    st = {session_active, correct_pin, current_balance};
    if (!rst && ((p != 5'b0) || (st != prev_st))) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event cyc=%0d got p=%b sa=%b cp=%0d cb=%0d",
                 cyc, p, session_active, correct_pin, current_balance);
      end else begin
        e = exp_q.pop_front();
        if ((e.at != cyc) || (e.p != p) || (e.sa != session_active) ||
            (e.cp != correct_pin) || (e.cb != current_balance)) begin
          miscompares++;
          $display("FAIL event got cyc=%0d p=%b sa=%b cp=%0d cb=%0d, want cyc=%0d p=%b sa=%b cp=%0d cb=%0d",
                   cyc, p, session_active, correct_pin, current_balance,
                   e.at, e.p, e.sa, e.cp, e.cb);
        end
      end
    end
    prev_st = st;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int at, input logic [4:0] p, input logic sa,
                      input logic [3:0] cp, input logic [4:0] cb);
    exp_t e;
    e.at = at; e.p = p; e.sa = sa; e.cp = cp; e.cb = cb;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic prog(input logic [1:0] idx, input logic [7:0] c,
                      input logic [3:0] pn, input logic [4:0] bal);
    prog_en = 1'b1; prog_idx = idx; prog_cardno = c; prog_pin = pn; prog_balance = bal;
    tick();
    prog_en = 1'b0;
  endtask

  // lat = edges after the accept edge at which the lookup result appears.
  task automatic insert(input logic [7:0] c, input int lat, input logic [4:0] p,
                        input logic sa, input logic [3:0] cp, input logic [4:0] cb);
    push(cyc + 1 + lat, p, sa, cp, cb);
    card_valid = 1'b1; cardno = c;
    tick();
    card_valid = 1'b0;
    tick(6);
  endtask

  task automatic enter_pin(input logic [3:0] v, input logic [4:0] p, input logic sa,
                           input logic [3:0] cp, input logic [4:0] cb);
    push(cyc + 1, p, sa, cp, cb);
    pin_valid = 1'b1; pin = v;
    tick();
    pin_valid = 1'b0;
    tick(2);
  endtask

  task automatic txn(input logic tv, input logic [4:0] bal, input logic se,
                     input logic sa, input logic [3:0] cp, input logic [4:0] cb);
    push(cyc + 1, 5'b0, sa, cp, cb);
    txn_valid = tv; txn_balance = bal; session_end = se;
    tick();
    txn_valid = 1'b0; session_end = 1'b0;
    tick(2);
  endtask

  function automatic int outs();
    return int'({auth_ok, auth_fail, card_reject, card_locked, timeout,
                 session_active, correct_pin, current_balance});
  endfunction

  initial begin
    int   c;
    exp_t e;
    rst = 1'b1;
    prog_en = 1'b0; prog_idx = '0; prog_cardno = '0; prog_pin = '0; prog_balance = '0;
    card_valid = 1'b0; cardno = '0; pin_valid = 1'b0; pin = '0;
    txn_valid = 1'b0; txn_balance = '0; session_end = 1'b0;
    tick(3);
    chk("reset_outputs", outs(), 0);
    rst = 1'b0;
    tick();
    chk("ready_idle", int'(card_ready), 1);

    // Table: idx2 and idx3 share card 0x5A so the lower index must win.
    prog(2'd2, 8'h5A, 4'd7, 5'd10);
    prog(2'd0, 8'h11, 4'd3, 5'd20);
    prog(2'd3, 8'h5A, 4'd9, 5'd2);
    tick();

    // Match at idx2: result three edges after accept.
    insert(8'h5A, 3, 5'b00000, 1'b0, 4'd7, 5'd10);
    chk("ready_busy", int'(card_ready), 0);
    enter_pin(4'd1, 5'b01000, 1'b0, 4'd7, 5'd10);
    enter_pin(4'd1, 5'b01000, 1'b0, 4'd7, 5'd10);
    enter_pin(4'd1, 5'b01010, 1'b0, 4'd0, 5'd0);
    insert(8'h5A, 3, 5'b00110, 1'b0, 4'd0, 5'd0);

    // Absent card scans the whole table.
    insert(8'h33, 4, 5'b00100, 1'b0, 4'd0, 5'd0);

    // Match at idx0 then a plain session end with nothing committed.
    insert(8'h11, 1, 5'b00000, 1'b0, 4'd3, 5'd20);
    enter_pin(4'd3, 5'b10000, 1'b1, 4'd3, 5'd20);
    txn(1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 5'd0);

    // Reprogramming unlocks; commit balance 4 and see it on re-login.
    prog(2'd2, 8'h5A, 4'd7, 5'd10);
    insert(8'h5A, 3, 5'b00000, 1'b0, 4'd7, 5'd10);
    enter_pin(4'd7, 5'b10000, 1'b1, 4'd7, 5'd10);
    txn(1'b1, 5'd4, 1'b0, 1'b1, 4'd7, 5'd4);
    txn(1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 5'd0);
    insert(8'h5A, 3, 5'b00000, 1'b0, 4'd7, 5'd4);
    enter_pin(4'd7, 5'b10000, 1'b1, 4'd7, 5'd4);

    // Commit and end in one cycle, then confirm 9 was stored.
    txn(1'b1, 5'd9, 1'b1, 1'b0, 4'd0, 5'd0);
    insert(8'h5A, 3, 5'b00000, 1'b0, 4'd7, 5'd9);
    enter_pin(4'd7, 5'b10000, 1'b1, 4'd7, 5'd9);

    // Programming during a session must not touch the table.
    prog(2'd2, 8'h5A, 4'd1, 5'd31);
    tick();
    txn(1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 5'd0);
    insert(8'h5A, 3, 5'b00000, 1'b0, 4'd7, 5'd9);
    enter_pin(4'd7, 5'b10000, 1'b1, 4'd7, 5'd9);

    // Reset mid-session clears outputs and the table.
    rst = 1'b1;
    #1;
    chk("midreset_outputs", outs(), 0);
    tick(2);
    chk("midreset_hold", outs(), 0);
    rst = 1'b0;
    tick();
    insert(8'h5A, 4, 5'b00100, 1'b0, 4'd0, 5'd0);
    insert(8'h11, 4, 5'b00100, 1'b0, 4'd0, 5'd0);

    // Inactivity timeout in WAIT_PIN after exactly TIMEOUT_CYCLES idle cycles.
    prog(2'd0, 8'h11, 4'd3, 5'd20);
    tick();
    c = cyc;
    push(c + 2, 5'b00000, 1'b0, 4'd3, 5'd20);
    push(c + 16, 5'b00001, 1'b0, 4'd0, 5'd0);
    card_valid = 1'b1; cardno = 8'h11;
    tick();
    card_valid = 1'b0;
    tick(20);

    // Programming and a card in the same cycle: programming wins, card ignored.
    prog_en = 1'b1; prog_idx = 2'd1; prog_cardno = 8'h22; prog_pin = 4'd5; prog_balance = 5'd6;
    card_valid = 1'b1; cardno = 8'h22;
    #1;
    chk("ready_during_prog", int'(card_ready), 0);
    tick();
    prog_en = 1'b0; card_valid = 1'b0;
    tick(6);
    insert(8'h22, 2, 5'b00000, 1'b0, 4'd5, 5'd6);
    tick(3);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event want cyc=%0d p=%b sa=%b cp=%0d cb=%0d", e.at, e.p, e.sa, e.cp, e.cb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
